vga_disp_scheduler: RTL and testbench



---
 rtl/vga_disp_scheduler_pkg.sv | 26 ++
 rtl/vga_disp_scheduler_if.sv | 31 +++
 rtl/vga_disp_scheduler_bin2bcd.sv | 62 ++++++
 rtl/vga_disp_scheduler.sv | 124 ++++++++++++
 tb/tb_vga_disp_scheduler.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/vga_disp_scheduler_pkg.sv
// Shared types and constants for the frame-synchronous VGA content scheduler.
package vga_disp_pkg;

    localparam int NUM_DIGITS = 7;
    localparam int REC_MAX    = 9999999;

    localparam logic [3:0] ADD3_THRESH = 4'd5;

    localparam logic [3:0] DIG_OFF  = 4'd0;
    localparam logic [3:0] DIG_MAN  = 4'd1;
    localparam logic [3:0] DIG_SEMI = 4'd2;
    localparam logic [3:0] DIG_AUTO = 4'd3;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        CONVERT,
        COMMIT
    } sched_state_e;

    // Double-dabble correction applied to one BCD nibble before each shift.
    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= ADD3_THRESH) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/vga_disp_scheduler_if.sv
// Control-side to renderer-side bundle around the scheduler.
interface vga_disp_if #(
    parameter int REC_W = 24
);
    import vga_disp_pkg::*;

    logic                    frame_start;
    logic                    power_on;
    logic [2:0]              mode_sel;
    logic                    show_record;
    logic                    alert;
    logic [REC_W-1:0]        record_val;

    logic [3:0]              state_digit;
    logic                    state_en;
    logic [4*NUM_DIGITS-1:0] rec_digits;
    logic                    rec_en;
    logic                    blink_phase;
    logic                    busy;

    modport master (
        output frame_start, power_on, mode_sel, show_record, alert, record_val,
        input  state_digit, state_en, rec_digits, rec_en, blink_phase, busy
    );

    modport slave (
        input  frame_start, power_on, mode_sel, show_record, alert, record_val,
        output state_digit, state_en, rec_digits, rec_en, blink_phase, busy
    );

endinterface

// File: rtl/vga_disp_scheduler_bin2bcd.sv
// Sequential double-dabble: loads on start_i, then runs REC_W add-3/shift iterations.
module bin2bcd_seq
    import vga_disp_pkg::*;
#(
    parameter int REC_W = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [REC_W-1:0]        bin_i,
    output logic                    done_o,
    output logic [4*NUM_DIGITS-1:0] bcd_o
);
    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int SR_W  = BCD_W + REC_W;
    localparam int CNT_W = $clog2(REC_W);

    logic [SR_W-1:0]  sr_q, sr_d, sr_adj;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             active_q, active_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        sr_adj = sr_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            sr_adj[REC_W + 4*i +: 4] = add3(sr_q[REC_W + 4*i +: 4]);
        end

        sr_d     = sr_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        if (start_i) begin
            sr_d     = {{BCD_W{1'b0}}, bin_i};
            cnt_d    = '0;
            active_d = 1'b1;
        end else if (active_q) begin
            sr_d  = {sr_adj[SR_W-2:0], 1'b0};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(REC_W - 1)) begin
                active_d = 1'b0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q     <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    // done_o flags the final iteration cycle so the caller can step to COMMIT on the same edge.
    assign done_o = active_q && (cnt_q == CNT_W'(REC_W - 1));
    assign bcd_o  = sr_q[SR_W-1 -: BCD_W];

endmodule

// File: rtl/vga_disp_scheduler.sv
// Once per frame: snapshot controls, convert the record to BCD, commit overlays during blanking.
module vga_disp_scheduler
    import vga_disp_pkg::*;
#(
    parameter int REC_W        = 24,
    parameter int BLINK_FRAMES = 30
) (
    input  logic     clk,
    input  logic     rst,
    vga_disp_if.slave bus
);
    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int FC_W  = $clog2(BLINK_FRAMES);

    sched_state_e      state_q, state_d;
    logic              power_q, show_q, alert_q;
    logic [2:0]        mode_q;
    logic [3:0]        state_digit_q, state_digit_d;
    logic              state_en_q, state_en_d;
    logic [BCD_W-1:0]  rec_digits_q, rec_digits_d;
    logic              rec_en_q, rec_en_d;
    logic              blink_q, blink_d;
    logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;

    logic [REC_W-1:0]  rec_sat;
    logic              conv_start, conv_done;
    logic [BCD_W-1:0]  conv_bcd;

    assign rec_sat    = (bus.record_val > REC_W'(REC_MAX)) ? REC_W'(REC_MAX) : bus.record_val;
    assign conv_start = (state_q == CAPTURE);

    bin2bcd_seq #(.REC_W(REC_W)) u_bin2bcd (
        .clk     (clk),
        .rst     (rst),
        .start_i (conv_start),
        .bin_i   (rec_sat),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd)
    );

    always_comb begin
        state_d       = state_q;
        state_digit_d = state_digit_q;
        state_en_d    = state_en_q;
        rec_digits_d  = rec_digits_q;
        rec_en_d      = rec_en_q;
        blink_d       = blink_q;
        frame_cnt_d   = frame_cnt_q;

        case (state_q)
            IDLE:    if (bus.frame_start) state_d = CAPTURE;
            CAPTURE: state_d = CONVERT;
            CONVERT: if (conv_done) state_d = COMMIT;
            COMMIT: begin
                state_d = IDLE;
                if (frame_cnt_q == FC_W'(BLINK_FRAMES - 1)) begin
                    frame_cnt_d = '0;
                    blink_d     = ~blink_q;
                end else begin
                    frame_cnt_d = frame_cnt_q + FC_W'(1);
                end

                rec_digits_d = conv_bcd;
                rec_en_d     = power_q && (mode_q == 3'b100) && show_q;

                if (!power_q) begin
                    state_digit_d = DIG_OFF;
                    state_en_d    = 1'b1;
                end else begin
                    // Invalid mode keeps the last digit but hides it.
                    case (mode_q)
                        3'b100:  begin state_digit_d = DIG_MAN;  state_en_d = 1'b1; end
                        3'b010:  begin state_digit_d = DIG_SEMI; state_en_d = 1'b1; end
                        3'b001:  begin state_digit_d = DIG_AUTO; state_en_d = 1'b1; end
                        default: state_en_d = 1'b0;
                    endcase
                end

                if (alert_q && power_q) begin
                    state_en_d = state_en_d & blink_d;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            state_digit_q <= DIG_OFF;
            state_en_q    <= 1'b0;
            rec_digits_q  <= '0;
            rec_en_q      <= 1'b0;
            blink_q       <= 1'b0;
            frame_cnt_q   <= '0;
            power_q       <= 1'b0;
            mode_q        <= '0;
            show_q        <= 1'b0;
            alert_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            state_digit_q <= state_digit_d;
            state_en_q    <= state_en_d;
            rec_digits_q  <= rec_digits_d;
            rec_en_q      <= rec_en_d;
            blink_q       <= blink_d;
            frame_cnt_q   <= frame_cnt_d;
            if (state_q == CAPTURE) begin
                power_q <= bus.power_on;
                mode_q  <= bus.mode_sel;
                show_q  <= bus.show_record;
                alert_q <= bus.alert;
            end
        end
    end

    assign bus.state_digit = state_digit_q;
    assign bus.state_en    = state_en_q;
    assign bus.rec_digits  = rec_digits_q;
    assign bus.rec_en      = rec_en_q;
    assign bus.blink_phase = blink_q;
    assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_vga_disp_scheduler.sv
// Self-checking bench: table-driven frames plus hand sequences, scored through an expected-result queue.
module tb_vga_disp_scheduler;

    localparam int REC_W   = 24;
    localparam int LAT     = REC_W + 2;
    localparam int BLINK_N = 30;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    vga_disp_if #(.REC_W(REC_W)) bus ();

    vga_disp_scheduler #(.REC_W(REC_W), .BLINK_FRAMES(BLINK_N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        p;
        logic [2:0]  m;
        logic        s;
        logic        a;
        logic [23:0] rec;
        logic [3:0]  dig;
        logic        en;
        logic        ren;
    } vec_t;

    typedef struct {
        logic [3:0]  digit;
        logic        en;
        logic [27:0] rec;
        logic        rec_en;
        logic        blink;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[10];
    int   checks    = 0;
    int   failures  = 0;
    int   n_commits = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [27:0] to_bcd(input logic [23:0] r);
        int          v;
        logic [27:0] out;
        v   = (r > 24'd9999999) ? 9999999 : int'(r);
        out = '0;
        for (int i = 0; i < 7; i++) begin
            out[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return out;
    endfunction

    task automatic drive(input logic p, input logic [2:0] m, input logic s, input logic a,
                         input logic [23:0] rec);
        bus.power_on    = p;
        bus.mode_sel    = m;
        bus.show_record = s;
        bus.alert       = a;
        bus.record_val  = rec;
    endtask

    task automatic push_exp(input logic [3:0] dig, input logic en, input logic ren,
                            input logic [23:0] rec);
        exp_t e;
        n_commits++;
        e.digit  = dig;
        e.en     = en;
        e.rec    = to_bcd(rec);
        e.rec_en = ren;
        e.blink  = 1'((n_commits / BLINK_N) % 2);
        sb_q.push_back(e);
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb_q.pop_front();
        check({tag, "_digit"}, 32'(bus.state_digit), 32'(e.digit));
        check({tag, "_en"},    32'(bus.state_en),    32'(e.en));
        check({tag, "_rec"},   32'(bus.rec_digits),  32'(e.rec));
        check({tag, "_recen"}, 32'(bus.rec_en),      32'(e.rec_en));
        check({tag, "_blink"}, 32'(bus.blink_phase), 32'(e.blink));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_digit"}, 32'(bus.state_digit), 32'd0);
        check({tag, "_en"},    32'(bus.state_en),    32'd0);
        check({tag, "_rec"},   32'(bus.rec_digits),  32'd0);
        check({tag, "_recen"}, 32'(bus.rec_en),      32'd0);
        check({tag, "_blink"}, 32'(bus.blink_phase), 32'd0);
        check({tag, "_busy"},  32'(bus.busy),        32'd0);
    endtask

    task automatic apply_reset();
        rst             = 1'b1;
        bus.frame_start = 1'b0;
        repeat (2) @(negedge clk);
        rst       = 1'b0;
        n_commits = 0;
    endtask

    // One full frame: pulse frame_start, wait (bounded) for busy to drop, then score.
    task automatic do_frame(input string tag, input logic p, input logic [2:0] m, input logic s,
                            input logic a, input logic [23:0] rec,
                            input logic [3:0] dig, input logic en, input logic ren);
        int n;
        drive(p, m, s, a, rec);
        bus.frame_start = 1'b1;
        push_exp(dig, en, ren, rec);
        @(negedge clk);
        bus.frame_start = 1'b0;
        n = 0;
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(LAT));
        compare_out(tag);
    endtask

    initial begin
        int busy_bad;
        int busy_seen;

        vecs[0] = '{1'b1, 3'b100, 1'b1, 1'b0, 24'hFFFFFF, 4'd1, 1'b1, 1'b1};
        vecs[1] = '{1'b0, 3'b100, 1'b1, 1'b0, 24'd42,     4'd0, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 3'b001, 1'b0, 1'b1, 24'd0,      4'd0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 3'b010, 1'b1, 1'b0, 24'd9999999,4'd2, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 3'b001, 1'b0, 1'b0, 24'd10000000,4'd3,1'b1, 1'b0};
        vecs[5] = '{1'b1, 3'b000, 1'b1, 1'b0, 24'd5,      4'd3, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 3'b110, 1'b1, 1'b0, 24'd99,     4'd3, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 3'b010, 1'b0, 1'b1, 24'd808080, 4'd2, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 3'b100, 1'b0, 1'b0, 24'd9999998,4'd1, 1'b1, 1'b0};
        vecs[9] = '{1'b1, 3'b100, 1'b1, 1'b0, 24'd0,      4'd1, 1'b1, 1'b1};

        bus.frame_start = 1'b0;
        drive(1'b0, 3'b000, 1'b0, 1'b0, 24'd0);
        @(negedge clk);
        apply_reset();
        check_reset_vals("reset");

        // Edge-accurate first frame: busy through edge 25, outputs land on edge 26.
        drive(1'b1, 3'b100, 1'b1, 1'b0, 24'd1234567);
        bus.frame_start = 1'b1;
        push_exp(4'd1, 1'b1, 1'b1, 24'd1234567);
        @(negedge clk);
        bus.frame_start = 1'b0;
        busy_bad = 0;
        for (int k = 0; k < LAT - 1; k++) begin
            if (!bus.busy) busy_bad++;
            @(negedge clk);
        end
        if (!bus.busy) busy_bad++;
        check("t1_busy_window", 32'(busy_bad), 32'd0);
        check("t1_no_early_recen", 32'(bus.rec_en), 32'd0);
        @(negedge clk);
        check("t1_busy_done", 32'(bus.busy), 32'd0);
        compare_out("t1");

        for (int i = 0; i < 10; i++) begin
            do_frame($sformatf("vec%0d", i), vecs[i].p, vecs[i].m, vecs[i].s, vecs[i].a,
                     vecs[i].rec, vecs[i].dig, vecs[i].en, vecs[i].ren);
        end

        // Extra frame_starts during CONVERT and in the COMMIT cycle are both ignored.
        drive(1'b1, 3'b001, 1'b1, 1'b0, 24'd7654321);
        bus.frame_start = 1'b1;
        push_exp(4'd3, 1'b1, 1'b0, 24'd7654321);
        @(negedge clk);
        bus.frame_start = 1'b0;
        repeat (9) @(negedge clk);
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
        repeat (LAT - 11) @(negedge clk);
        check("dbl_busy_e25", 32'(bus.busy), 32'd1);
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
        check("dbl_busy_e26", 32'(bus.busy), 32'd0);
        compare_out("dbl");
        busy_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.busy) busy_seen++;
        end
        check("dbl_no_restart", 32'(busy_seen), 32'd0);

        // Reset landing on CONVERT iteration 12 (edge 14) aborts without a partial commit.
        drive(1'b1, 3'b100, 1'b1, 1'b0, 24'd555);
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
        repeat (13) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        n_commits = 0;
        check_reset_vals("midrst");
        repeat (30) @(negedge clk);
        check("midrst_no_commit", 32'(bus.rec_digits), 32'd0);
        do_frame("postrst", 1'b1, 3'b100, 1'b1, 1'b0, 24'd8765432, 4'd1, 1'b1, 1'b1);

        // Alert blink: 60 frames, toggles at commits 30 and 60, digit hidden while phase is 0.
        apply_reset();
        for (int f = 0; f < 60; f++) begin
            logic bl;
            bl = 1'(((f + 1) / BLINK_N) % 2);
            do_frame($sformatf("blink%0d", f), 1'b1, 3'b100, 1'b1, 1'b1, 24'(f * 1111),
                     4'd1, bl, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
